// File: rtl/snake_pattern_gen.sv
// Frame source for the LED snake: computes eight GRB words per request, one
// segment per cycle into a shadow set, then loads them onto the outputs at once.
module snake_pattern_gen #(
  parameter int STEP_FRAMES = 4,
  parameter int DIV_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dir_mode,
  input  logic [3:0]  snake_len,
  input  logic [23:0] colour,
  input  logic        new_frames_set_rqst,
  output logic [23:0] led0,
  output logic [23:0] led1,
  output logic [23:0] led2,
  output logic [23:0] led3,
  output logic [23:0] led4,
  output logic [23:0] led5,
  output logic [23:0] led6,
  output logic [23:0] led7,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CALC, S_LOAD} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_rqst_d;
  logic             r_overrun;
  logic [2:0]       r_pos;
  logic             r_dir_down;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_k;
  logic [3:0]       r_len;
  logic [7:0]       r_written;
  logic [23:0]      r_shadow [8];
  logic [23:0]      r_led    [8];

  logic             w_rise;
  logic             w_calc_entry;
  logic [2:0]       w_pos_nxt;
  logic             w_dir_nxt;
  logic [3:0]       w_len;
  logic [3:0]       w_down_sum;
  logic [2:0]       w_seg_pos;
  logic             w_seg_valid;
  logic             w_draw;
  logic [23:0]      w_seg_col;

  assign w_rise       = new_frames_set_rqst & ~r_rqst_d;
  assign w_calc_entry = (w_next == S_CALC) && (r_state != S_CALC);
  assign busy         = (r_state == S_CALC) || (r_state == S_LOAD);
  assign overrun      = r_overrun;

  assign w_len = (snake_len == 4'd0) ? 4'd1 : ((snake_len > 4'd8) ? 4'd8 : snake_len);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_CALC;
        S_WAIT:  if (w_rise) w_next = S_CALC;
        S_CALC:  if (r_k == 3'd7) w_next = S_LOAD;
        S_LOAD:  w_next = S_WAIT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Next position/direction for an advance; wrap mode always leaves dir up.
  always_comb begin
    w_pos_nxt = r_pos + 3'd1;
    w_dir_nxt = 1'b0;
    if (dir_mode) begin
      if (!r_dir_down && r_pos == 3'd7) begin
        w_dir_nxt = 1'b1;
        w_pos_nxt = 3'd6;
      end else if (r_dir_down && r_pos == 3'd0) begin
        w_dir_nxt = 1'b0;
        w_pos_nxt = 3'd1;
      end else begin
        w_dir_nxt = r_dir_down;
        w_pos_nxt = r_dir_down ? (r_pos - 3'd1) : (r_pos + 3'd1);
      end
    end
  end

  // Segment k position; bounce mode drops segments that fall off the strip.
  assign w_down_sum = {1'b0, r_pos} + {1'b0, r_k};

  always_comb begin
    w_seg_pos   = r_pos - r_k;
    w_seg_valid = 1'b1;
    if (dir_mode) begin
      if (r_dir_down) begin
        w_seg_pos   = w_down_sum[2:0];
        w_seg_valid = ~w_down_sum[3];
      end else begin
        w_seg_valid = (r_k <= r_pos);
      end
    end
  end

  assign w_draw    = ({1'b0, r_k} < r_len) && w_seg_valid && !r_written[w_seg_pos];
  assign w_seg_col = {colour[23:16] >> r_k, colour[15:8] >> r_k, colour[7:0] >> r_k};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every one samples pre-edge values.
    if (rst) begin
      r_rqst_d   <= 1'b0;
      r_overrun  <= 1'b0;
      r_pos      <= 3'd0;
      r_dir_down <= 1'b0;
      r_div      <= '0;
      r_k        <= 3'd0;
      r_len      <= 4'd1;
      r_written  <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 24'd0;
        r_led[i]    <= 24'd0;
      end
    end else begin
      r_rqst_d <= new_frames_set_rqst;
      if (!enable) begin
        r_overrun  <= 1'b0;
        r_pos      <= 3'd0;
        r_dir_down <= 1'b0;
        r_div      <= '0;
        r_k        <= 3'd0;
        for (int i = 0; i < 8; i++) r_led[i] <= 24'd0;
      end else begin
        if (r_state == S_WAIT && w_rise) begin
          if (r_div == DIV_LAST) begin
            r_div      <= '0;
            r_pos      <= w_pos_nxt;
            r_dir_down <= w_dir_nxt;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        if (busy && w_rise) r_overrun <= 1'b1;

        if (w_calc_entry) begin
          r_k       <= 3'd0;
          r_len     <= w_len;
          r_written <= 8'd0;
          for (int i = 0; i < 8; i++) r_shadow[i] <= 24'd0;
        end else if (r_state == S_CALC) begin
          r_k <= r_k + 3'd1;
          if (w_draw) begin
            r_shadow[w_seg_pos]  <= w_seg_col;
            r_written[w_seg_pos] <= 1'b1;
          end
        end

        if (r_state == S_LOAD) begin
          for (int i = 0; i < 8; i++) r_led[i] <= r_shadow[i];
        end
      end
    end
  end

  assign led0 = r_led[0];
  assign led1 = r_led[1];
  assign led2 = r_led[2];
  assign led3 = r_led[3];
  assign led4 = r_led[4];
  assign led5 = r_led[5];
  assign led6 = r_led[6];
  assign led7 = r_led[7];

endmodule

// File: tb/tb_snake_pattern_gen.sv
// Bench for snake_pattern_gen: one instance with STEP_FRAMES=1, one with 4,
// sharing all inputs; table-driven frame checks plus timing corner sequences.
module tb_snake_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir_mode;
  logic [3:0]  snake_len;
  logic [23:0] colour;
  logic        rqst;

  logic [23:0] a_led0, a_led1, a_led2, a_led3, a_led4, a_led5, a_led6, a_led7;
  logic [23:0] b_led0, b_led1, b_led2, b_led3, b_led4, b_led5, b_led6, b_led7;
  logic        a_busy, a_overrun, b_busy, b_overrun;
  logic [23:0] ga [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snake_pattern_gen #(.STEP_FRAMES(1), .DIV_W(8)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .dir_mode(dir_mode),
    .snake_len(snake_len), .colour(colour), .new_frames_set_rqst(rqst),
    .led0(a_led0), .led1(a_led1), .led2(a_led2), .led3(a_led3),
    .led4(a_led4), .led5(a_led5), .led6(a_led6), .led7(a_led7),
    .busy(a_busy), .overrun(a_overrun)
  );

  snake_pattern_gen #(.STEP_FRAMES(4), .DIV_W(8)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .dir_mode(dir_mode),
    .snake_len(snake_len), .colour(colour), .new_frames_set_rqst(rqst),
    .led0(b_led0), .led1(b_led1), .led2(b_led2), .led3(b_led3),
    .led4(b_led4), .led5(b_led5), .led6(b_led6), .led7(b_led7),
    .busy(b_busy), .overrun(b_overrun)
  );

  assign ga[0] = a_led0; assign ga[1] = a_led1; assign ga[2] = a_led2; assign ga[3] = a_led3;
  assign ga[4] = a_led4; assign ga[5] = a_led5; assign ga[6] = a_led6; assign ga[7] = a_led7;

  typedef struct {
    logic              dm;
    logic [3:0]        len;
    logic [23:0]       col;
    int                pulses;
    logic [7:0][23:0]  exp;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [7:0][23:0] pk(input logic [23:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk) rqst = 1'b1;
    @(negedge clk) rqst = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic restart(input logic dm, input logic [3:0] len, input logic [23:0] col);
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    dir_mode  = dm;
    snake_len = len;
    colour    = col;
    enable    = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    localparam logic [23:0] H = 24'hFF8040;
    localparam logic [23:0] Z = 24'h000000;

    vecs[0] = '{dm: 1'b0, len: 4'd3,  col: H, pulses: 0,  exp: pk(H, Z, Z, Z, Z, Z, 24'h3F2010, 24'h7F4020)};
    vecs[1] = '{dm: 1'b0, len: 4'd3,  col: H, pulses: 1,  exp: pk(24'h7F4020, H, Z, Z, Z, Z, Z, 24'h3F2010)};
    vecs[2] = '{dm: 1'b1, len: 4'd2,  col: H, pulses: 7,  exp: pk(Z, Z, Z, Z, Z, Z, 24'h7F4020, H)};
    vecs[3] = '{dm: 1'b1, len: 4'd2,  col: H, pulses: 8,  exp: pk(Z, Z, Z, Z, Z, Z, H, 24'h7F4020)};
    vecs[4] = '{dm: 1'b1, len: 4'd2,  col: H, pulses: 14, exp: pk(H, 24'h7F4020, Z, Z, Z, Z, Z, Z)};
    vecs[5] = '{dm: 1'b1, len: 4'd2,  col: H, pulses: 15, exp: pk(24'h7F4020, H, Z, Z, Z, Z, Z, Z)};
    vecs[6] = '{dm: 1'b0, len: 4'd0,  col: H, pulses: 0,  exp: pk(H, Z, Z, Z, Z, Z, Z, Z)};
    vecs[7] = '{dm: 1'b0, len: 4'd12, col: H, pulses: 0,
                exp: pk(H, 24'h010100, 24'h030201, 24'h070402, 24'h0F0804, 24'h1F1008, 24'h3F2010, 24'h7F4020)};
    vecs[8] = '{dm: 1'b1, len: 4'd8,  col: H, pulses: 0,  exp: pk(H, Z, Z, Z, Z, Z, Z, Z)};
    vecs[9] = '{dm: 1'b0, len: 4'd2,  col: 24'h123456, pulses: 3,
                exp: pk(Z, Z, 24'h091A2B, 24'h123456, Z, Z, Z, Z)};

    rst = 1'b1; enable = 1'b0; dir_mode = 1'b0; snake_len = 4'd1; colour = 24'h0; rqst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset led0", {8'h0, a_led0}, 32'h0);
    check("reset led7", {8'h0, a_led7}, 32'h0);
    check("reset busy", {31'h0, a_busy}, 32'h0);
    check("reset overrun", {31'h0, a_overrun}, 32'h0);
    rst = 1'b0;

    // Table-driven frame contents on the STEP_FRAMES=1 instance.
    for (int v = 0; v < 10; v++) begin
      restart(vecs[v].dm, vecs[v].len, vecs[v].col);
      for (int p = 0; p < vecs[v].pulses; p++) pulse();
      for (int i = 0; i < 8; i++)
        check($sformatf("vec%0d led%0d", v, i), {8'h0, ga[i]}, {8'h0, vecs[v].exp[i]});
    end

    // STEP_FRAMES=4: three requests hold the head, the fourth advances it;
    // outputs hold for 9 cycles after the request edge.
    restart(1'b0, 4'd1, H);
    repeat (3) pulse();
    check("div4 hold led0", {8'h0, b_led0}, {8'h0, H});
    check("div4 hold led1", {8'h0, b_led1}, 32'h0);
    @(negedge clk) rqst = 1'b1;
    @(negedge clk) rqst = 1'b0;
    check("div4 busy", {31'h0, b_busy}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("div4 stable%0d led0", i), {8'h0, b_led0}, {8'h0, H});
      check($sformatf("div4 stable%0d led1", i), {8'h0, b_led1}, 32'h0);
      @(negedge clk);
    end
    check("div4 step led0", {8'h0, b_led0}, 32'h0);
    check("div4 step led1", {8'h0, b_led1}, {8'h0, H});

    // Second request while busy: sticky overrun, single advance.
    restart(1'b0, 4'd1, H);
    @(negedge clk) rqst = 1'b1;
    @(negedge clk) rqst = 1'b0;
    repeat (2) @(negedge clk);
    rqst = 1'b1;
    @(negedge clk) rqst = 1'b0;
    repeat (12) @(negedge clk);
    check("ovr flag", {31'h0, a_overrun}, 32'h1);
    check("ovr led0", {8'h0, a_led0}, 32'h0);
    check("ovr led1", {8'h0, a_led1}, {8'h0, H});
    check("ovr led2", {8'h0, a_led2}, 32'h0);
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) check($sformatf("disable led%0d", i), {8'h0, ga[i]}, 32'h0);
    check("disable overrun", {31'h0, a_overrun}, 32'h0);
    check("disable busy", {31'h0, a_busy}, 32'h0);

    // Asynchronous reset in the middle of CALC.
    restart(1'b0, 4'd1, H);
    pulse();
    check("pre-rst led1", {8'h0, a_led1}, {8'h0, H});
    @(negedge clk) rqst = 1'b1;
    @(negedge clk) rqst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-calc busy", {31'h0, a_busy}, 32'h1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("async rst led%0d", i), {8'h0, ga[i]}, 32'h0);
    check("async rst busy", {31'h0, a_busy}, 32'h0);
    #3 rst = 1'b0;
    repeat (11) @(negedge clk);
    check("post-rst led0", {8'h0, a_led0}, {8'h0, H});
    check("post-rst led1", {8'h0, a_led1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snake_pattern_gen.md
Name: snake_pattern_gen

Overview:
Upstream frame source for led_snake_top. Produces the eight 24-bit GRB colour words led0..led7 that the serializer latches. It animates a fading "snake" that moves one LED per STEP_FRAMES frame requests, in wrap or bounce mode. Each new frame set is computed sequentially in response to the serializer's new_frames_set_rqst.

Parameters:
STEP_FRAMES, 4, number of frame requests per one-LED snake step (>=1)
DIV_W, 8, width of the request divider counter (2**DIV_W >= STEP_FRAMES)

Ports:
clk  input  1  system clock (25 MHz nominal)
rst  input  1  reset, asynchronous, active-high; one clock domain
enable  input  1  1 = animate; 0 = all LEDs off, state cleared
dir_mode  input  1  0 = wrap around the strip, 1 = bounce at the ends
snake_len  input  4  requested snake length; clamped to 1..8
colour  input  24  head colour, GRB, 8 bits per channel
new_frames_set_rqst  input  1  request from led_snake_top; treated as a level, edge-detected internally
led0..led7  output  24 each  frame words to the serializer; registered
busy  output  1  high while a frame set is being computed (CALC/LOAD)
overrun  output  1  sticky: a request edge arrived while busy; cleared only by rst or enable=0

Behaviour:
- Reset (async, rst=1): led0..7=0, busy=0, overrun=0, pos=0, dir=up, div=0, rqst_d=0, state=IDLE.
- Request edge: rise = rqst & ~rqst_d, with rqst_d registered every cycle.
- Outputs change only in LOAD. They are stable for at least 10 cycles after any request edge, so the serializer latches the previous set on its request cycle.
- FSM states: IDLE, WAIT, CALC, LOAD.
  - IDLE: outputs 0. On enable=1, go to CALC without advancing (pos=0).
  - WAIT: on rise, update the divider/position (below), then go to CALC. No rise: stay in WAIT.
  - CALC: 8 cycles, k=0..7. Each cycle writes segment k into the shadow registers (shadow cleared on CALC entry).
  - LOAD: 1 cycle. Copy shadow to led0..7, then return to WAIT. busy=1 in CALC and LOAD only.
- Latency: rise in WAIT at cycle N -> new led0..7 visible at cycle N+10.
- enable=0 in any state: next edge goes to IDLE. On that edge led0..7=0, pos=0, dir=up, div=0, overrun=0.
- Divider on rise in WAIT: if div==STEP_FRAMES-1, then div<=0 and the snake advances; else div<=div+1. CALC always recomputes, so colour/len changes take effect on every request.
- Advance, wrap mode: pos<=(pos+1) mod 8.
- Advance, bounce mode:
  - up and pos==7: dir<=down, pos<=6
  - down and pos==0: dir<=up, pos<=1
  - otherwise pos±1 per dir
- Switching dir_mode mid-run takes effect at the next advance. In wrap mode dir is forced up.
- Length L = (snake_len==0) ? 1 : min(snake_len, 8), sampled at CALC entry. Segments k >= L are not drawn.
- Segment position:
  - wrap: (pos-k) mod 8
  - bounce, dir up: pos-k
  - bounce, dir down: pos+k
  - bounce positions outside 0..7 are not drawn
- Segment colour: each 8-bit channel of colour is logically shifted right by k, independently.
- Overlap: a position already written in this CALC keeps its lower-k value.
- Rise while busy: ignored (no divider/position change) and sets overrun=1.
- rst asserted mid-CALC: immediate full reset, and the shadow is discarded.

Test Plan:
1. STEP_FRAMES=1, dir_mode=0, snake_len=3, colour=0xFF8040; release rst, enable=1 -> after 10 cycles led0=0xFF8040, led7=0x7F4020, led6=0x3F2010, others 0. One rqst pulse -> 10 cycles later led1=0xFF8040, led0=0x7F4020, led7=0x3F2010.
2. STEP_FRAMES=4, wrap, len=1 -> three rqst pulses leave only led0 lit. The fourth rqst moves the head to led1. Outputs never change within 9 cycles of any request edge.
3. Bounce, len=2, STEP_FRAMES=1:
   - After 7 requests: led7=head, led6=head>>1.
   - 8th request: led6=head, led7=head>>1.
   - After 14 requests: led0=head, led1=half. 15th request: led1=head, led0=half.
4. Length clamp, wrap, colour=0xFF8040:
   - snake_len=0 -> exactly one LED non-zero.
   - snake_len=12 -> all 8 non-zero, tail-end LED (k=7) = 0x010100.
5. Second rqst pulse 3 cycles after the first (during CALC) -> overrun=1, position advanced once only. Then enable=0 -> next cycle all leds 0, overrun=0.
6. Assert rst for one half-cycle mid-CALC -> led0..7=0, busy=0 immediately (asynchronous, before next clk edge). After release with enable=1, the frame restarts at pos=0.
